ahblite_slave_mux: RTL and testbench

//  Data-phase response multiplexer for the AHB-Lite matrix. Sits directly downstream of the

---
 rtl/ahblite_pkg.sv | 18 +
 rtl/ahblite_default_slave.sv | 48 ++++
 rtl/ahblite_slave_mux.sv | 136 +++++++++++++
 tb/tb_ahblite_slave_mux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the slave response mux.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers active transfers to unmapped space with the two-cycle AHB ERROR response.
module ahblite_default_slave
    import ahblite_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_hready,
    input  logic i_unmappedActive,
    output logic o_hreadyOut,
    output logic o_hresp
);

    ds_state_t r_state;
    logic      r_hreadyOut;
    logic      r_hresp;

    // Outputs are registered alongside the state so they follow it with no decode logic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= DS_IDLE;
            r_hreadyOut <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                DS_ERR1: begin
                    r_state     <= DS_ERR2;
                    r_hreadyOut <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (i_hready && i_unmappedActive) begin
                        r_state     <= DS_ERR1;
                        r_hreadyOut <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end else begin
                        r_state     <= DS_IDLE;
                        r_hreadyOut <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign o_hreadyOut = r_hreadyOut;
    assign o_hresp     = r_hresp;

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response mux with built-in default slave.
// Optional stall watchdog enabled by defining AHBLITE_MUX_TIMEOUT_EN.
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter int PORT0_EN       = 1,
    parameter int PORT1_EN       = 1,
    parameter int PORT2_EN       = 1,
    parameter int PORT3_EN       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_hclk,
    input  logic        i_hresetn,
    input  logic [1:0]  i_htrans,
    input  logic        i_p0_hsel,
    input  logic        i_p1_hsel,
    input  logic        i_p2_hsel,
    input  logic        i_p3_hsel,
    input  logic [31:0] i_p0_hrdata,
    input  logic [31:0] i_p1_hrdata,
    input  logic [31:0] i_p2_hrdata,
    input  logic [31:0] i_p3_hrdata,
    input  logic        i_p0_hreadyout,
    input  logic        i_p1_hreadyout,
    input  logic        i_p2_hreadyout,
    input  logic        i_p3_hreadyout,
    input  logic        i_p0_hresp,
    input  logic        i_p1_hresp,
    input  logic        i_p2_hresp,
    input  logic        i_p3_hresp,
    output logic        o_hready,
    output logic [31:0] o_hrdata,
    output logic        o_hresp,
    input  logic        i_timeout_clr,
    output logic        o_timeout_irq
);

    logic [3:0]  r_sel;
    logic [3:0]  w_selEn;
    logic [3:0]  w_selNext;
    logic        w_active;
    logic        w_dsReady;
    logic        w_dsResp;
    logic        w_hready;
    logic        w_hresp;
    logic [31:0] w_hrdata;
    logic        w_unused;

    assign w_selEn = {i_p3_hsel & (PORT3_EN != 0), i_p2_hsel & (PORT2_EN != 0),
                      i_p1_hsel & (PORT1_EN != 0), i_p0_hsel & (PORT0_EN != 0)};
    assign w_active = (i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ);

    always_comb begin
        w_selNext = 4'b0000;
        if (w_selEn[0])      w_selNext = 4'b0001;
        else if (w_selEn[1]) w_selNext = 4'b0010;
        else if (w_selEn[2]) w_selNext = 4'b0100;
        else if (w_selEn[3]) w_selNext = 4'b1000;
    end

    // Select is captured only when an address phase is accepted, so stalls freeze it.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_sel <= 4'b0000;
        end else if (w_hready) begin
            r_sel <= w_selNext;
        end
    end

    ahblite_default_slave u_defaultSlave (
        .i_clk            (i_hclk),
        .i_rst_n          (i_hresetn),
        .i_hready         (w_hready),
        .i_unmappedActive (w_active && (w_selEn == 4'b0000)),
        .o_hreadyOut      (w_dsReady),
        .o_hresp          (w_dsResp)
    );

    always_comb begin
        w_hrdata = 32'h0000_0000;
        w_hready = w_dsReady;
        w_hresp  = w_dsResp;
        if (r_sel[0]) begin
            w_hrdata = i_p0_hrdata; w_hready = i_p0_hreadyout; w_hresp = i_p0_hresp;
        end else if (r_sel[1]) begin
            w_hrdata = i_p1_hrdata; w_hready = i_p1_hreadyout; w_hresp = i_p1_hresp;
        end else if (r_sel[2]) begin
            w_hrdata = i_p2_hrdata; w_hready = i_p2_hreadyout; w_hresp = i_p2_hresp;
        end else if (r_sel[3]) begin
            w_hrdata = i_p3_hrdata; w_hready = i_p3_hreadyout; w_hresp = i_p3_hresp;
        end
    end

    assign o_hready = w_hready;
    assign o_hrdata = w_hrdata;
    assign o_hresp  = w_hresp;

`ifdef AHBLITE_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          r_irq;

    always_comb begin
        w_cntNext = r_cnt;
        if (w_hready) begin
            w_cntNext = '0;
        end else if ((r_sel != 4'b0000) && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
            w_cntNext = r_cnt + CW'(1);
        end
    end

    // Flag rises on the edge the count reaches the limit; a new hit beats a same-cycle clear.
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_cntNext;
            if (w_cntNext == CW'(TIMEOUT_CYCLES)) begin
                r_irq <= 1'b1;
            end else if (i_timeout_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign o_timeout_irq = r_irq;
    assign w_unused      = 1'b0;
`else
    assign o_timeout_irq = 1'b0;
    assign w_unused      = i_timeout_clr;
`endif

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux (port 3 disabled, watchdog limit 8).
module tb_ahblite_slave_mux;

`ifdef AHBLITE_MUX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hsel0 = 0, hsel1 = 0, hsel2 = 0, hsel3 = 0;
    logic [31:0] rdata0 = 32'h00C0_FFEE, rdata1 = 32'h1111_1111;
    logic [31:0] rdata2 = 32'h2222_2222, rdata3 = 32'h3333_3333;
    logic        rdy0 = 1, rdy1 = 1, rdy2 = 1, rdy3 = 1;
    logic        resp0 = 0, resp1 = 0, resp2 = 0, resp3 = 0;
    logic        timeoutClr = 0;
    logic        hready, hresp, timeoutIrq;
    logic [31:0] hrdata;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    ahblite_slave_mux #(
        .PORT0_EN(1), .PORT1_EN(1), .PORT2_EN(1), .PORT3_EN(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_hclk(clk), .i_hresetn(rstN), .i_htrans(htrans),
        .i_p0_hsel(hsel0), .i_p1_hsel(hsel1), .i_p2_hsel(hsel2), .i_p3_hsel(hsel3),
        .i_p0_hrdata(rdata0), .i_p1_hrdata(rdata1), .i_p2_hrdata(rdata2), .i_p3_hrdata(rdata3),
        .i_p0_hreadyout(rdy0), .i_p1_hreadyout(rdy1), .i_p2_hreadyout(rdy2), .i_p3_hreadyout(rdy3),
        .i_p0_hresp(resp0), .i_p1_hresp(resp1), .i_p2_hresp(resp2), .i_p3_hresp(resp3),
        .o_hready(hready), .o_hrdata(hrdata), .o_hresp(hresp),
        .i_timeout_clr(timeoutClr), .o_timeout_irq(timeoutIrq)
    );

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBus(input string tag, input logic expRdy, input logic expResp,
                            input logic [31:0] expData);
        #1;
        checkOutput({tag, "_hready"}, {31'b0, hready}, {31'b0, expRdy});
        checkOutput({tag, "_hresp"},  {31'b0, hresp},  {31'b0, expResp});
        checkOutput({tag, "_hrdata"}, hrdata, expData);
    endtask

    initial begin
        // Reset state
        nextCycle();
        checkBus("reset", 1'b1, 1'b0, 32'h0);
        checkOutput("reset_irq", {31'b0, timeoutIrq}, 32'h0);
        rstN = 1'b1;

        // P1 read, then P2 address pipelined behind it
        nextCycle();
        hsel1 = 1; htrans = 2'b10;
        nextCycle();
        hsel1 = 0; hsel2 = 1; rdata1 = 32'hDEAD_BEEF;
        checkBus("p1_read", 1'b1, 1'b0, 32'hDEAD_BEEF);

        // P2 stalls three cycles while P3 select toggles
        nextCycle();
        hsel2 = 0; hsel3 = 1; rdy2 = 0;
        checkBus("p2_stall1", 1'b0, 1'b0, 32'h2222_2222);
        nextCycle();
        hsel3 = 0;
        checkBus("p2_stall2", 1'b0, 1'b0, 32'h2222_2222);
        nextCycle();
        hsel3 = 1;
        checkBus("p2_stall3", 1'b0, 1'b0, 32'h2222_2222);
        nextCycle();
        hsel3 = 0; rdy2 = 1; htrans = 2'b00;
        checkBus("p2_done", 1'b1, 1'b0, 32'h2222_2222);

        // IDLE to unmapped: OKAY; then NONSEQ to unmapped: two-cycle ERROR
        nextCycle();
        htrans = 2'b10;
        checkBus("unmap_idle", 1'b1, 1'b0, 32'h0);
        nextCycle();
        htrans = 2'b00;
        checkBus("err1", 1'b0, 1'b1, 32'h0);
        nextCycle();
        checkBus("err2", 1'b1, 1'b1, 32'h0);
        nextCycle();
        checkBus("err_after", 1'b1, 1'b0, 32'h0);

        // Disabled port 3 behaves as unmapped; back-to-back errors, then unmapped->P0
        hsel3 = 1; htrans = 2'b10;
        nextCycle();
        checkBus("p3dis_err1", 1'b0, 1'b1, 32'h0);
        nextCycle();
        checkBus("p3dis_err2", 1'b1, 1'b1, 32'h0);
        nextCycle();
        hsel3 = 0; htrans = 2'b00;
        checkBus("b2b_err1", 1'b0, 1'b1, 32'h0);
        nextCycle();
        hsel0 = 1; htrans = 2'b10;
        checkBus("b2b_err2", 1'b1, 1'b1, 32'h0);
        nextCycle();
        resp0 = 1;
        checkBus("p0_after_err", 1'b1, 1'b1, 32'h00C0_FFEE);

        // P0 stall for the watchdog: 8 stalled edges
        nextCycle();
        hsel0 = 0; htrans = 2'b00; resp0 = 0; rdy0 = 0;
        checkBus("p0_stall_start", 1'b0, 1'b0, 32'h00C0_FFEE);
        for (int i = 0; i < 7; i++) nextCycle();
        #1;
        checkOutput("irq_before_limit", {31'b0, timeoutIrq}, 32'h0);
        nextCycle();
        #1;
        checkOutput("irq_at_limit", {31'b0, timeoutIrq}, {31'b0, TO_EN});
        rdy0 = 1;
        nextCycle();
        #1;
        checkOutput("irq_sticky", {31'b0, timeoutIrq}, {31'b0, TO_EN});
        timeoutClr = 1;
        nextCycle();
        timeoutClr = 0;
        #1;
        checkOutput("irq_cleared", {31'b0, timeoutIrq}, 32'h0);

        // Asynchronous reset during ERR1, then a clean P0 read
        htrans = 2'b10;
        nextCycle();
        htrans = 2'b00;
        checkBus("pre_reset_err1", 1'b0, 1'b1, 32'h0);
        rstN = 1'b0;
        checkBus("async_reset", 1'b1, 1'b0, 32'h0);
        nextCycle();
        rstN = 1'b1;
        hsel0 = 1; htrans = 2'b10;
        nextCycle();
        hsel0 = 0; htrans = 2'b00;
        checkBus("post_reset_p0", 1'b1, 1'b0, 32'h00C0_FFEE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
